ifu_inst_queue: RTL
===================

// Module: ifu_inst_queue
// PURPOSE
//   Instruction queue between the IFU AXI read-return path and the decode stage (IDU).
//   Buffers fetched {pc, inst, err} entries in a DEPTH-entry FIFO and presents them to IDU with valid/ready.
//   On a pipeline redirect it flushes all entries. It drops stale in-flight returns using a fetch epoch tag.
// PARAMETERS
//   DEPTH       4   queue entries; power of 2, >= 2
//   PC_WIDTH    32  fetch address width
//   INST_WIDTH  32  instruction width
//   EPOCH_WIDTH 2   fetch epoch tag width; wraps modulo 2^EPOCH_WIDTH
// PORTS
//   clk          in   1                single clock; all state updates on its rising edge
//   rst          in   1                synchronous reset, active-high
//   flush        in   1                redirect: clear queue, advance epoch
//   cur_epoch    out  EPOCH_WIDTH      epoch the IFU must tag new fetches with
//   fetch_valid  in   1                IFU return valid (R beat with rlast)
//   fetch_ready  out  1                queue can accept a return
//   fetch_pc     in   PC_WIDTH         address of returned instruction
//   fetch_inst   in   INST_WIDTH       returned instruction word
//   fetch_err    in   1                rresp != OKAY for this beat
//   fetch_epoch  in   EPOCH_WIDTH      epoch tag the fetch was issued under
//   idu_valid    out  1                head entry valid
//   idu_ready    in   1                IDU consumes head
//   idu_pc       out  PC_WIDTH         head pc
//   idu_inst     out  INST_WIDTH       head instruction
//   idu_err      out  1                head fetch error (IDU raises access fault)
//   q_count      out  clog2(DEPTH)+1   current occupancy
//   drop_cnt     out  16               stale returns discarded; saturates at 16'hFFFF
// BEHAVIOUR
//   Reset: count=0, wr/rd ptrs=0, cur_epoch=0, drop_cnt=0.
//     Outputs during reset: idu_valid=0, fetch_ready=0.
//     idu_pc/idu_inst/idu_err are don't-care while idu_valid=0.
//   Storage: register array indexed by wr_ptr/rd_ptr (clog2(DEPTH) bits, natural wrap at DEPTH).
//   fetch_ready = !rst && (count < DEPTH). It is a function of registered count only.
//     No combinational path from idu_ready. A pop in a full cycle does not admit a push that same cycle.
//   idu_valid = (count != 0) && !flush. idu_pc/inst/err read combinationally from mem[rd_ptr].
//   push = fetch_valid && fetch_ready && !flush && (fetch_epoch == cur_epoch).
//   stale = fetch_valid && fetch_ready && !flush && (fetch_epoch != cur_epoch).
//     A stale beat is handshaken, not stored, and increments drop_cnt (saturating).
//   pop = idu_valid && idu_ready.
//   push only: write at wr_ptr, wr_ptr+1, count+1.
//   pop only: rd_ptr+1, count-1.
//   push && pop: both ptrs advance, count unchanged. Legal whenever count in [1, DEPTH-1].
//     At count=0 there is no pop, so no bypass: latency fetch->idu_valid is 1 cycle.
//   flush (highest priority):
//     - next cycle count=0 and wr_ptr=rd_ptr=0;
//     - cur_epoch+1 (mod 2^EPOCH_WIDTH);
//     - any same-cycle fetch beat is handshaken (fetch_ready as normal) but discarded, NOT counted in drop_cnt;
//     - no pop occurs.
//   Back-to-back flush: epoch advances each cycle. The IFU must retag after each flush.
//   Entries hold pc/inst/err unchanged until popped. The err bit is carried, never filtered.
//   Asserting rst mid-operation discards all entries and restores the reset state at the next edge, regardless of flush/fetch.
// TESTING
//   1. Reset, push pc 0x40000000..0x4000000C, idu_ready=1 -> idu_pc appears in order, one per cycle, 1-cycle latency.
//   2. idu_ready=0, push 5 beats -> 4 accepted, fetch_ready=0 at count=4.
//      Release idu_ready -> fetch_ready returns 1 cycle after the first pop.
//   3. count=2, push+pop same cycle -> count stays 2, order preserved.
//   4. count=3, flush with concurrent fetch -> next cycle count=0, idu_valid=0, cur_epoch 0->1, drop_cnt unchanged.
//   5. After flush, return tagged epoch 0 -> discarded, drop_cnt=1. Return tagged epoch 1 -> delivered.
//   6. fetch_err=1 beat at 0x40000010 -> idu_err=1 with that pc. Then 4 flushes -> cur_epoch wraps back to its start value.

Source files
------------

// File: rtl/ifu_inst_queue.sv
// Instruction queue between the IFU read-return path and the decode stage.
// Holds {pc, inst, err} entries in a DEPTH-entry circular buffer, hands them
// to IDU with valid/ready, and uses a fetch epoch tag to discard returns that
// were issued before the most recent redirect.
module ifu_inst_queue #(
   parameter int DEPTH       = 4,
   parameter int PC_WIDTH    = 32,
   parameter int INST_WIDTH  = 32,
   parameter int EPOCH_WIDTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   output logic [EPOCH_WIDTH-1:0]    cur_epoch,
   input  logic                      fetch_valid,
   output logic                      fetch_ready,
   input  logic [PC_WIDTH-1:0]       fetch_pc,
   input  logic [INST_WIDTH-1:0]     fetch_inst,
   input  logic                      fetch_err,
   input  logic [EPOCH_WIDTH-1:0]    fetch_epoch,
   output logic                      idu_valid,
   input  logic                      idu_ready,
   output logic [PC_WIDTH-1:0]       idu_pc,
   output logic [INST_WIDTH-1:0]     idu_inst,
   output logic                      idu_err,
   output logic [$clog2(DEPTH):0]    q_count,
   output logic [15:0]               drop_cnt
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = PC_WIDTH + INST_WIDTH + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [ENTRY_W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [CNT_W-1:0]       count;
   logic [EPOCH_WIDTH-1:0] epoch;
   logic [15:0]            drops;

   logic beat;
   logic epoch_match;
   logic push;
   logic stale;
   logic pop;

   // Handshake qualification; fetch_ready depends on registered count only,
   // so a pop in a full cycle never opens room for a same-cycle push.
   always_comb begin
      fetch_ready = !rst && (count < FULL_CNT);
      idu_valid   = !rst && (count != '0) && !flush;
      beat        = fetch_valid && fetch_ready && !flush;
      epoch_match = (fetch_epoch == epoch);
      push        = beat && epoch_match;
      stale       = beat && !epoch_match;
      pop         = idu_valid && idu_ready;
   end

   // Head entry is read straight out of the array.
   always_comb begin
      {idu_pc, idu_inst, idu_err} = mem[rd_ptr];
   end

   // Entry storage; written only on an accepted, current-epoch push.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wr_ptr] <= {fetch_pc, fetch_inst, fetch_err};
      end
   end

   // Pointers, occupancy, epoch and drop counter. Flush outranks everything
   // except reset and suppresses both push and pop for that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         epoch  <= '0;
         drops  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         epoch  <= epoch + EPOCH_WIDTH'(1);
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (stale && (drops != 16'hFFFF)) begin
            drops <= drops + 16'd1;
         end
      end
   end

   assign cur_epoch = epoch;
   assign q_count   = count;
   assign drop_cnt  = drops;

endmodule
